seven_seg_bcd_display: RTL and testbench



---
 rtl/lab1_display_pkg.sv | 38 +++
 rtl/seven_seg_bcd_display_decoder.sv | 30 +++
 rtl/seven_seg_bcd_display.sv | 117 +++++++++++
 tb/tb_seven_seg_bcd_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lab1_display_pkg.sv
// Shared display types and constants: FSM states, active-low segment codes,
// and the per-nibble add-3 correction used by the double-dabble engine.
package lab1_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int BCD_DIGITS  = 4;
    localparam int SHIFT_STEPS = 13;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] b);
        logic [4*BCD_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_bcd_display_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern, zero latency.
// i_blank or an out-of-range nibble (10..15) drives all segments off.
module seg7_decoder
    import lab1_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_bcd_display.sv
// Binary-to-BCD (sequential double-dabble) driving four active-low 7-seg digits.
// 15 cycles from load to o_valid; input changes during a conversion wait for S_IDLE.
module seven_seg_bcd_display
    import lab1_display_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1,
    parameter int WIDTH         = 13
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_value,
    output logic [6:0]       o_hex0,
    output logic [6:0]       o_hex1,
    output logic [6:0]       o_hex2,
    output logic [6:0]       o_hex3,
    output logic             o_busy,
    output logic             o_valid
);

    localparam int BCD_W = 4 * BCD_DIGITS;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_last;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_cnt;
    logic             r_force;
    logic [6:0]       r_hex0, r_hex1, r_hex2, r_hex3;
    logic             r_valid;

    logic [BCD_W-1:0] w_bcd_adj;
    logic             w_start;
    logic             w_last_step;
    logic             w_blank1, w_blank2, w_blank3;
    logic [6:0]       w_seg0, w_seg1, w_seg2, w_seg3;

    assign w_bcd_adj   = bcd_adjust(r_bcd);
    assign w_start     = (i_value != r_last) || r_force;
    assign w_last_step = (r_cnt == 4'(SHIFT_STEPS - 1));

    // A digit blanks only when it and every digit above it are zero
    assign w_blank3 = BLANK_LEADING && (r_bcd[15:12] == 4'd0);
    assign w_blank2 = w_blank3 && (r_bcd[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);

    seg7_decoder u_dec0 (.i_nibble(r_bcd[3:0]),   .i_blank(1'b0),     .o_seg(w_seg0));
    seg7_decoder u_dec1 (.i_nibble(r_bcd[7:4]),   .i_blank(w_blank1), .o_seg(w_seg1));
    seg7_decoder u_dec2 (.i_nibble(r_bcd[11:8]),  .i_blank(w_blank2), .o_seg(w_seg2));
    seg7_decoder u_dec3 (.i_nibble(r_bcd[15:12]), .i_blank(w_blank3), .o_seg(w_seg3));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_step) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_force <= 1'b1;
            r_hex0  <= SEG_BLANK;
            r_hex1  <= SEG_BLANK;
            r_hex2  <= SEG_BLANK;
            r_hex3  <= SEG_BLANK;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shift <= i_value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_last  <= i_value;
                        r_force <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + 4'd1;
                end
                S_DONE: begin
                    r_hex0  <= w_seg0;
                    r_hex1  <= w_seg1;
                    r_hex2  <= w_seg2;
                    r_hex3  <= w_seg3;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_hex0  = r_hex0;
    assign o_hex1  = r_hex1;
    assign o_hex2  = r_hex2;
    assign o_hex3  = r_hex3;
    assign o_busy  = (r_state != S_IDLE);
    assign o_valid = r_valid;

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Directed and random checks of the BCD display against a decimal-arithmetic model,
// with one instance blanking leading zeros and one showing them.
module tb_seven_seg_bcd_display;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] val   = '0;

    logic [6:0] a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
    logic       a_busy, a_valid, b_busy, b_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seven_seg_bcd_display #(.BLANK_LEADING(1'b1), .WIDTH(13)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(val),
        .o_hex0(a_h0), .o_hex1(a_h1), .o_hex2(a_h2), .o_hex3(a_h3),
        .o_busy(a_busy), .o_valid(a_valid)
    );

    seven_seg_bcd_display #(.BLANK_LEADING(1'b0), .WIDTH(13)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(val),
        .o_hex0(b_h0), .o_hex1(b_h1), .o_hex2(b_h2), .o_hex3(b_h3),
        .o_busy(b_busy), .o_valid(b_valid)
    );

    // Expected {hex3,hex2,hex1,hex0}: digit k is blank when v < 10^k (k > 0)
    function automatic logic [27:0] exp_disp(input int v, input bit blank);
        logic [27:0] r;
        int p;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (blank && k > 0 && v < p) r[7*k +: 7] = 7'h7F;
            else                         r[7*k +: 7] = seg_tbl[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!a_valid && cycles < 40);
        check({tag, "_valid_seen"}, {31'd0, a_valid}, 32'd1);
    endtask

    task automatic check_disp(input string tag, input int v);
        check({tag, "_hexA"}, {4'd0, a_h3, a_h2, a_h1, a_h0}, {4'd0, exp_disp(v, 1'b1)});
        check({tag, "_hexB"}, {4'd0, b_h3, b_h2, b_h1, b_h0}, {4'd0, exp_disp(v, 1'b0)});
        check({tag, "_validB"}, {31'd0, b_valid}, 32'd1);
    endtask

    task automatic show(input string tag, input int v);
        int cyc;
        val = 13'(v);
        wait_valid(tag, cyc);
        check({tag, "_latency"}, cyc, 32'd15);
        check_disp(tag, v);
    endtask

    initial begin
        int cyc;
        int pulses;
        int v;
        int prev;

        // Reset state
        val   = 13'd0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_hexA", {4'd0, a_h3, a_h2, a_h1, a_h0}, {4'd0, {4{7'h7F}}});
        check("rst_hexB", {4'd0, b_h3, b_h2, b_h1, b_h0}, {4'd0, {4{7'h7F}}});
        check("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        check("rst_valid", {30'd0, a_valid, b_valid}, 32'd0);

        // Forced conversion of 0 after release
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            check($sformatf("first_busy_e%0d", e), {30'd0, a_busy, a_valid}, 32'd2);
        end
        tick();
        check("first_valid_e15", {30'd0, a_busy, a_valid}, 32'd1);
        check_disp("zero", 0);
        tick();
        check("first_valid_drop", {30'd0, a_valid, b_valid}, 32'd0);

        // Directed values
        show("v8191", 8191);
        show("v7", 7);

        // Change mid-conversion: first update is 1024, then 4096
        val = 13'd1024;
        repeat (5) tick();
        val = 13'd4096;
        wait_valid("v1024", cyc);
        check("v1024_latency", cyc, 32'd10);
        check_disp("v1024", 1024);
        wait_valid("v4096", cyc);
        check("v4096_latency", cyc, 32'd15);
        check_disp("v4096", 4096);

        // Reset during a conversion of 555
        val = 13'd555;
        repeat (7) tick();
        check("mid_busy_pre", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hexA", {4'd0, a_h3, a_h2, a_h1, a_h0}, {4'd0, {4{7'h7F}}});
        check("mid_rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("v555", cyc);
        check("v555_latency", cyc, 32'd15);
        check_disp("v555", 555);

        // Stable input: no further pulses, display holds
        show("v300", 300);
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (a_valid) pulses++;
            if (a_busy) pulses++;
        end
        check("hold_pulses", pulses, 32'd0);
        check("hold_hexA", {4'd0, a_h3, a_h2, a_h1, a_h0}, {4'd0, exp_disp(300, 1'b1)});

        // Random values
        prev = 300;
        for (int i = 0; i < 24; i++) begin
            do v = int'($urandom_range(0, 8191)); while (v == prev);
            show($sformatf("rnd%0d_%0d", i, v), v);
            prev = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
